// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg -- shared types and constants for the memory arbiter slice.
//   word_t      : 32-bit machine word
//   ramstate_t  : RAM handshake state (FREE/BUSY/ACCESS/ERROR)
//   arb_state_t : arbiter FSM state (IDLE/OWN)
//   IBURST/DBURST : ACCESS beats per instruction/data grant
package cpu_types_pkg;
   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      FREE   = 2'b00,
      BUSY   = 2'b01,
      ACCESS = 2'b10,
      ERROR  = 2'b11
   } ramstate_t;

   typedef enum logic {
      IDLE = 1'b0,
      OWN  = 1'b1
   } arb_state_t;

   localparam int unsigned N_CPU  = 2;
   localparam logic [1:0]  IBURST = 2'd1;
   localparam logic [1:0]  DBURST = 2'd2;

   function automatic logic [1:0] burst_len(input logic is_data);
      return is_data ? DBURST : IBURST;
   endfunction
endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// arb_pick -- combinational winner selection for mem_arbiter.
//   iREN/dREN/dWEN : per-CPU request vectors
//   last_cpu       : CPU served by the previous grant (the other one wins a tie)
//   valid          : at least one request pending
//   cpu            : winning CPU index
//   is_data        : winner is served as a data request (data beats instruction)
module arb_pick
   import cpu_types_pkg::*;
(
   input  logic [N_CPU-1:0] iREN,
   input  logic [N_CPU-1:0] dREN,
   input  logic [N_CPU-1:0] dWEN,
   input  logic             last_cpu,
   output logic             valid,
   output logic             cpu,
   output logic             is_data
);
   logic [N_CPU-1:0] d_req;
   logic [N_CPU-1:0] any_req;

   always_comb begin
      d_req   = dREN | dWEN;
      any_req = d_req | iREN;
      valid   = |any_req;
      cpu     = 1'b0;
      if (any_req[0] && any_req[1])
         cpu = ~last_cpu;
      else if (any_req[1])
         cpu = 1'b1;
      is_data = d_req[cpu];
   end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter -- two-CPU instruction/data arbiter onto a single RAM port.
//   CLK, nRST                : clock, asynchronous active-low reset
//   iREN/iaddr               : per-CPU instruction read request/address
//   dREN/dWEN/daddr/dstore   : per-CPU data read/write request, address, word
//   iwait/dwait              : per-CPU stalls (low only on the owner's ACCESS beat)
//   iload/dload              : ramload broadcast to every CPU
//   ramREN/ramWEN/ramaddr/ramstore : RAM request driven from the owner only
//   ramload/ramstate         : RAM read data and handshake state
// Configuration macro ARB_ROUND_ROBIN_EN: round-robin between CPUs when
// defined; otherwise CPU0 always wins and no pointer register exists.
module mem_arbiter
   import cpu_types_pkg::*;
(
   input  logic                  CLK,
   input  logic                  nRST,
   input  logic [N_CPU-1:0]      iREN,
   input  word_t [N_CPU-1:0]     iaddr,
   input  logic [N_CPU-1:0]      dREN,
   input  logic [N_CPU-1:0]      dWEN,
   input  word_t [N_CPU-1:0]     daddr,
   input  word_t [N_CPU-1:0]     dstore,
   output logic [N_CPU-1:0]      iwait,
   output logic [N_CPU-1:0]      dwait,
   output word_t [N_CPU-1:0]     iload,
   output word_t [N_CPU-1:0]     dload,
   output logic                  ramREN,
   output logic                  ramWEN,
   output word_t                 ramaddr,
   output word_t                 ramstore,
   input  word_t                 ramload,
   input  ramstate_t             ramstate
);
   arb_state_t state;
   logic       own_cpu;
   logic       own_data;
   logic [1:0] beats;
   logic       last_cpu;
   logic       pick_valid;
   logic       pick_cpu;
   logic       pick_data;
   logic       own_req;
   logic       drive;

`ifndef ARB_ROUND_ROBIN_EN
   // Pretending CPU1 was always served last makes CPU0 win every tie.
   assign last_cpu = 1'b1;
`endif

   arb_pick u_pick (
      .iREN     (iREN),
      .dREN     (dREN),
      .dWEN     (dWEN),
      .last_cpu (last_cpu),
      .valid    (pick_valid),
      .cpu      (pick_cpu),
      .is_data  (pick_data)
   );

   // Owner still asserting the request class it was granted for.
   assign own_req = own_data ? (dREN[own_cpu] | dWEN[own_cpu]) : iREN[own_cpu];
   assign drive   = (state == OWN) && own_req;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state    <= IDLE;
         own_cpu  <= 1'b0;
         own_data <= 1'b0;
         beats    <= '0;
`ifdef ARB_ROUND_ROBIN_EN
         last_cpu <= 1'b1;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (pick_valid) begin
                  state    <= OWN;
                  own_cpu  <= pick_cpu;
                  own_data <= pick_data;
                  beats    <= '0;
`ifdef ARB_ROUND_ROBIN_EN
                  last_cpu <= pick_cpu;
`endif
               end
            end
            OWN: begin
               if (!own_req) begin
                  state <= IDLE;
                  beats <= '0;
               end else if (ramstate == ACCESS) begin
                  if ((beats + 2'd1) == burst_len(own_data)) begin
                     state <= IDLE;
                     beats <= '0;
                  end else begin
                     beats <= beats + 2'd1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // RAM side and stalls follow the live request lines so a dropped request
   // stops RAM traffic in the same cycle.
   always_comb begin
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = '0;
      ramstore = '0;
      iwait    = '1;
      dwait    = '1;
      if (drive) begin
         if (own_data) begin
            ramWEN            = dWEN[own_cpu];
            ramREN            = dREN[own_cpu] && !dWEN[own_cpu];
            ramaddr           = daddr[own_cpu];
            ramstore          = dstore[own_cpu];
            dwait[own_cpu]    = (ramstate != ACCESS);
         end else begin
            ramREN            = 1'b1;
            ramaddr           = iaddr[own_cpu];
            iwait[own_cpu]    = (ramstate != ACCESS);
         end
      end
   end

   always_comb begin
      for (int unsigned c = 0; c < N_CPU; c++) begin
         iload[c] = ramload;
         dload[c] = ramload;
      end
   end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: CLK  in  1  rising-edge clock; nRST  in  1  asynchronous active-low reset.
REQ-002 The block SHALL have these CPU-side ports, with N=2 CPUs and index = CPUID:
- iREN  in  2  instruction read request
- iaddr  in  2x32  instruction address
- dREN  in  2  data read request
- dWEN  in  2  data write request
- daddr  in  2x32  data address
- dstore  in  2x32  data write word
- iwait  out  2  instruction stall
- dwait  out  2  data stall
- iload  out  2x32  instruction read data
- dload  out  2x32  data read data
REQ-003 The block SHALL have these RAM-side ports:
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data
- ramstate  in  ramstate_t  FREE/BUSY/ACCESS/ERROR

Function
REQ-004 The FSM SHALL have two states: IDLE (no owner) and OWN (one requester granted).
REQ-005 In IDLE with any request pending, the block SHALL latch a winner into an owner register and enter OWN on the next edge; arbitration latency is 1 cycle.
REQ-006 Within a CPU, a data request (dREN or dWEN) SHALL win over iREN.
REQ-007 Between CPUs, priority SHALL rotate round-robin: the CPU not served by the last grant wins a tie; the pointer updates on every grant.
REQ-008 In OWN, the block SHALL drive ramREN, ramWEN, ramaddr and ramstore from the owner's signals only.
- Data owner: ramWEN=dWEN, ramREN=dREN && !dWEN.
- Instruction owner: ramREN=1.
REQ-009 The owner's wait output SHALL be 0 only in cycles where ramstate==ACCESS; every other wait output SHALL be 1.
REQ-010 iload and dload SHALL all equal ramload, broadcast combinationally.
REQ-011 The block SHALL count ACCESS beats per grant. It SHALL release to IDLE after IBURST beats for an instruction owner and DBURST beats for a data owner.
REQ-012 If the owner drops all its request lines mid-burst, the block SHALL release to IDLE on the next edge without driving RAM in that cycle.
REQ-013 ramstate BUSY, FREE or ERROR SHALL hold the owner stalled; the beat counter SHALL NOT advance.
REQ-014 The block SHALL arbitrate again only from IDLE; a request arriving in the release cycle waits 1 cycle.
REQ-015 A writeback burst followed by a fetch burst from the same dcache SHALL be two separate grants.

Reset
REQ-016 On nRST low the block SHALL enter IDLE with no owner, beat count 0 and round-robin pointer at CPU1, so that CPU0 wins the first tie.
REQ-017 While in reset: ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, all iwait=1, all dwait=1.
REQ-018 Reset mid-burst SHALL abandon the burst immediately, with no further RAM enables.

Configuration
REQ-019 With ARB_ROUND_ROBIN_EN defined, inter-CPU priority SHALL be round-robin per REQ-007.
REQ-020 Without ARB_ROUND_ROBIN_EN, CPU0 SHALL always win over CPU1, and the pointer register SHALL be absent.

Structure
REQ-021 The constants IBURST=1, DBURST=2 and the arb_state_t enum SHALL live in cpu_types_pkg beside word_t and ramstate_t.
REQ-022 A sub-module arb_pick SHALL implement the combinational winner selection from request vectors and the pointer. It SHALL return CPU index and an is-data flag.

Verification
REQ-023 The bench SHALL cover these scenarios:
- dREN[0] at daddr=0x40, RAM returns 0xAAAA then 0xBBBB on two ACCESS cycles -> dwait[0] low exactly twice, dload[0] matches each, then IDLE.
- iREN[0] and dWEN[0] asserted together -> data granted first; iwait[0] stays 1 until the 2-beat write completes.
- dREN[0] and dREN[1] held continuously -> grants alternate CPU0, CPU1, CPU0; without ARB_ROUND_ROBIN_EN, CPU0 every time.
- ramstate BUSY for 3 cycles then ACCESS -> owner wait stays 1 for 3 cycles, and the beat count does not advance.
- Owner drops dREN after 1 beat -> IDLE next edge, ramREN=0, pending iREN[1] granted the cycle after.
- nRST asserted in OWN mid-burst -> ramREN/ramWEN=0 immediately, all waits=1, IDLE after release.
